xadc_drp_reader: RTL and testbench
==================================

// Module: xadc_drp_reader
// PURPOSE
//  Consumer end of the conversion-trigger path. On each 1-cycle trigger pulse (issued in step with XADC EOC),
//  reads NUM_CH channel result registers from the XADC over the DRP read port, one read at a time.
//  Presents all results together as one frame with a 1-cycle valid strobe to the 3LFCC control loop.
//  Flags DRP timeouts and triggers that arrive while a frame is still being read.
// PARAMETERS
//  NUM_CH      3             channels per frame, range 1..8
//  CH_ADDRS    {7'h11,7'h10,7'h03}  packed NUM_CH*7 DRP addresses; slot i = CH_ADDRS[7*i +: 7]; slot 0 is read first
//  TIMEOUT     64            max cycles from den to drdy before abort, range 2..1023
// PORTS
//  clk           in   1          system clock, 125 MHz
//  rst_n         in   1          asynchronous active-low reset
//  trigger       in   1          1-cycle start pulse from the timer controller
//  drp_den       out  1          DRP enable, 1-cycle pulse per read
//  drp_dwe       out  1          DRP write enable, tied 0
//  drp_daddr     out  7          DRP address, valid while drp_den=1
//  drp_di        out  16         DRP write data, tied 0
//  drp_do        in   16         DRP read data, sampled when drp_drdy=1
//  drp_drdy      in   1          DRP read-data ready
//  busy          out  1          high from the cycle after an accepted trigger until the cycle of valid/error
//  sample_valid  out  1          1-cycle strobe: sample_data holds a complete new frame
//  sample_data   out  NUM_CH*12  slot i = [12*i +: 12] = drp_do[15:4] of read i
//  timeout_err   out  1          1-cycle pulse: read aborted, no drdy within TIMEOUT
//  missed_trig   out  1          1-cycle pulse: trigger arrived while busy=1; that trigger is dropped
// BEHAVIOUR
//  - Reset: every output is 0, sample_data is 0, FSM is in IDLE, channel index is 0, timeout counter is 0.
//    Reset takes effect at once, including in the middle of a read. drp_den drops immediately.
//    After release, a late drdy is ignored because the FSM is in IDLE.
//  - FSM states: IDLE -> REQ -> WAIT -> (REQ | DONE) -> IDLE.
//    IDLE: trigger=1 -> REQ. Load channel index 0 and set busy.
//    REQ: hold drp_den=1 and drp_daddr=CH_ADDRS slot[idx] for exactly 1 cycle -> WAIT. Clear the timeout counter.
//    WAIT: drp_den=0.
//      - drdy=1: capture drp_do[15:4] into a staging register at slot idx.
//        If idx < NUM_CH-1, increment idx and go to REQ. Otherwise go to DONE.
//      - drdy=0: increment the counter. When the counter reaches TIMEOUT-1, pulse timeout_err, go to IDLE, clear busy.
//        In this case sample_data keeps its previous frame and sample_valid is not asserted.
//    DONE: copy the staging register to sample_data, pulse sample_valid, clear busy -> IDLE.
//  - Latency, with trigger at cycle T and drdy k>=1 cycles after each den:
//    den at T+1; next den 1 cycle after each drdy; sample_valid at T+1+NUM_CH*(k+1)+1.
//    With k=1 and NUM_CH=3, sample_valid is at T+8.
//  - sample_data updates only in DONE and is atomic: it never mixes two frames.
//  - Any trigger while not in IDLE -> missed_trig pulse in the same cycle. The FSM is unaffected.
//  - A trigger in the same cycle as DONE or timeout counts as missed. A new frame starts only from IDLE.
//  - drdy in IDLE, REQ or DONE is ignored. drdy in the same cycle as the timeout limit is accepted; the timeout does not fire.
//  - At most one DRP transaction is outstanding. drp_den is never asserted twice without an intervening drdy or abort.
//  - Arithmetic: the timeout counter is $clog2(TIMEOUT+1) bits and saturates. idx is $clog2(NUM_CH) bits (minimum 1).
//    No wrap-around is possible.
// STRUCTURE
//  - Shared package xadc_pkg: ADC_W=12; DRP_AW=7; DRP address constants XADC_ADDR_VPVN=7'h03,
//    XADC_ADDR_AUX0=7'h10, XADC_ADDR_AUX1=7'h11; typedef drp_rd_state_t {IDLE, REQ, WAIT, DONE}.
//  - One sub-module: drp_read_port. It performs a single DRP read with timeout
//    (inputs start, addr; outputs den, daddr, rdata, done, timeout).
//    The top level holds the FSM sequencing, the index, and the staging and output registers.
// TESTING
//  - Nominal: model responds drdy 1 cycle after den with do=16'hABC0, 16'h1230, 16'h7FF0; trigger at T
//    -> daddr 03,10,11 in order; sample_valid at T+8; sample_data={12'h7FF,12'h123,12'hABC}.
//  - Timeout: model never answers slot 1 -> timeout_err at 64 cycles after the second den; no sample_valid;
//    sample_data keeps the previous frame; busy=0; the next trigger starts from slot 0.
//  - Overlap: second trigger 3 cycles after the first -> missed_trig 1 cycle; exactly one sample_valid; only 3 den pulses.
//  - Boundary drdy: drdy arrives exactly at cycle TIMEOUT-1 of WAIT -> data accepted; no timeout_err.
//  - Reset mid-frame: rst_n low during WAIT of slot 1, then drdy arrives after release -> all outputs 0;
//    drdy ignored; no den until the next trigger.
//  - Stray and variable latency: drdy pulsed in IDLE -> no effect; random k in 1..20 over 100 frames
//    -> every frame matches the model and no den is issued while a read is outstanding.

Source files
------------

// File: rtl/xadc_pkg.sv
// Shared XADC constants and the DRP reader state encoding.
package xadc_pkg;

  localparam int ADC_W  = 12;
  localparam int DRP_AW = 7;

  localparam logic [DRP_AW-1:0] XADC_ADDR_VPVN = 7'h03;
  localparam logic [DRP_AW-1:0] XADC_ADDR_AUX0 = 7'h10;
  localparam logic [DRP_AW-1:0] XADC_ADDR_AUX1 = 7'h11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } drp_rd_state_t;

endpackage

// File: rtl/xadc_drp_reader_if.sv
// XADC DRP port bundle; master is the reader, slave is the XADC primitive.
interface xadc_drp_reader_if;
  import xadc_pkg::*;

  logic              drp_den;
  logic              drp_dwe;
  logic [DRP_AW-1:0] drp_daddr;
  logic [15:0]       drp_di;
  logic [15:0]       drp_do;
  logic              drp_drdy;

  modport master (
    output drp_den, drp_dwe, drp_daddr, drp_di,
    input  drp_do, drp_drdy
  );

  modport slave (
    input  drp_den, drp_dwe, drp_daddr, drp_di,
    output drp_do, drp_drdy
  );

endinterface

// File: rtl/drp_read_port.sv
// Single DRP read: pulses den for one cycle on start, then waits for drdy or aborts.
// Latency: den one cycle after start; done/timeout combinational in the drdy/limit cycle.
// Backpressure: none; start must only be pulsed when no read is outstanding.
module drp_read_port
  import xadc_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DRP_AW-1:0] addr,
  input  logic [15:0]       drp_do,
  input  logic              drp_drdy,
  output logic              den,
  output logic [DRP_AW-1:0] daddr,
  output logic [ADC_W-1:0]  rdata,
  output logic              done,
  output logic              timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT - 1);

  logic             pend;
  logic             waiting;
  logic [CNT_W-1:0] cnt;
  logic             unused_lsbs;

  // drdy is only meaningful after the den cycle; drdy wins over the limit.
  assign waiting     = pend & ~den;
  assign done        = waiting & drp_drdy;
  assign timeout     = waiting & ~drp_drdy & (cnt == CNT_LIMIT);
  assign rdata       = drp_do[15:4];
  assign unused_lsbs = ^drp_do[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      den   <= 1'b0;
      daddr <= '0;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      den <= start;
      if (start) begin
        daddr <= addr;
        cnt   <= '0;
        pend  <= 1'b1;
      end else begin
        if (done || timeout)
          pend <= 1'b0;
        if (waiting && !drp_drdy && cnt != CNT_MAX)
          cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/xadc_drp_reader.sv
// Reads NUM_CH XADC result registers over DRP per trigger and emits them as one frame.
// Latency: sample_valid at T+1+NUM_CH*(k+1)+1 for trigger at T and drdy k cycles after each den.
// Backpressure: none; triggers arriving while busy are dropped and flagged on missed_trig.
module xadc_drp_reader
  import xadc_pkg::*;
#(
  parameter int                       NUM_CH   = 3,
  parameter logic [NUM_CH*DRP_AW-1:0] CH_ADDRS = {XADC_ADDR_AUX1, XADC_ADDR_AUX0, XADC_ADDR_VPVN},
  parameter int                       TIMEOUT  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    trigger,
  xadc_drp_reader_if.master       drp,
  output logic                    busy,
  output logic                    sample_valid,
  output logic [NUM_CH*ADC_W-1:0] sample_data,
  output logic                    timeout_err,
  output logic                    missed_trig
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);

  drp_rd_state_t           state;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        nxt_idx;
  logic                    start;
  logic                    rp_done;
  logic                    rp_timeout;
  logic [DRP_AW-1:0]       rp_addr;
  logic [ADC_W-1:0]        rp_rdata;
  logic [NUM_CH*ADC_W-1:0] stage;

  // Next read is issued in the same edge that enters REQ, so den lines up with REQ.
  always_comb begin
    start   = 1'b0;
    nxt_idx = '0;
    if (state == IDLE && trigger) begin
      start = 1'b1;
    end else if (state == WAIT && rp_done && idx != LAST) begin
      start   = 1'b1;
      nxt_idx = idx + 1'b1;
    end
  end

  assign rp_addr     = CH_ADDRS[DRP_AW*nxt_idx +: DRP_AW];
  assign busy        = (state != IDLE);
  assign missed_trig = trigger && (state != IDLE);

  assign drp.drp_dwe = 1'b0;
  assign drp.drp_di  = '0;

  drp_read_port #(
    .TIMEOUT (TIMEOUT)
  ) u_read_port (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .addr     (rp_addr),
    .drp_do   (drp.drp_do),
    .drp_drdy (drp.drp_drdy),
    .den      (drp.drp_den),
    .daddr    (drp.drp_daddr),
    .rdata    (rp_rdata),
    .done     (rp_done),
    .timeout  (rp_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      stage        <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            idx   <= '0;
            state <= REQ;
          end
        end
        REQ: state <= WAIT;
        WAIT: begin
          if (rp_done) begin
            stage[ADC_W*idx +: ADC_W] <= rp_rdata;
            if (idx == LAST) begin
              state <= DONE;
            end else begin
              idx   <= nxt_idx;
              state <= REQ;
            end
          end else if (rp_timeout) begin
            // Aborted frame: sample_data keeps the last complete frame.
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        DONE: begin
          sample_data  <= stage;
          sample_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_drp_reader.sv
// Directed bench for xadc_drp_reader with a DRP responder model driven from the main process.
module tb_xadc_drp_reader;
  import xadc_pkg::*;

  localparam int NUM_CH = 3;
  localparam int DW     = NUM_CH * ADC_W;

  typedef struct {
    int            k;
    logic [15:0]   d0, d1, d2;
    bit            exp_ok;
    int            exp_off;
    logic [DW-1:0] exp_data;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trigger = 1'b0;
  logic          busy, sample_valid, timeout_err, missed_trig;
  logic [DW-1:0] sample_data;

  xadc_drp_reader_if drp ();

  xadc_drp_reader #(
    .NUM_CH   (NUM_CH),
    .CH_ADDRS ({XADC_ADDR_AUX1, XADC_ADDR_AUX0, XADC_ADDR_VPVN}),
    .TIMEOUT  (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trigger      (trigger),
    .drp          (drp),
    .busy         (busy),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .timeout_err  (timeout_err),
    .missed_trig  (missed_trig)
  );

  always #4 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int cd = 0, cur_slot = 0, k_fix = 1;
  bit rand_k = 1'b0, mute_aux0 = 1'b0;
  logic [15:0] resp_data [3];
  int n_den = 0, n_valid = 0, n_to = 0, n_miss = 0, n_overlap = 0;
  int ev_valid = -1, ev_to = -1, ev_miss = -1;
  logic ev_busy = 1'b1;
  logic [DRP_AW-1:0] addr_q [$];
  int t0, d0, v0, to0, m0;
  vec_t vecs [6];
  logic [DW-1:0] exp_frame;
  logic [15:0] r0, r1, r2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int slot_of(input logic [DRP_AW-1:0] a);
    if (a == XADC_ADDR_AUX0) return 1;
    if (a == XADC_ADDR_AUX1) return 2;
    return 0;
  endfunction

  function automatic logic [3*DRP_AW-1:0] pack_addrs();
    logic [3*DRP_AW-1:0] r;
    r = '0;
    if (addr_q.size() != 3) return '1;
    for (int j = 0; j < 3; j++) r[DRP_AW*j +: DRP_AW] = addr_q[j];
    return r;
  endfunction

  // Observe at negedge, then drive the responder for the next cycle just after posedge.
  task automatic tick();
    @(negedge clk);
    if (drp.drp_den) begin
      n_den++;
      addr_q.push_back(drp.drp_daddr);
      if (cd > 0) n_overlap++;
      if (!(mute_aux0 && drp.drp_daddr == XADC_ADDR_AUX0)) begin
        cd       = rand_k ? int'($urandom_range(20, 1)) : k_fix;
        cur_slot = slot_of(drp.drp_daddr);
      end
    end
    if (sample_valid) begin n_valid++; ev_valid = cyc; ev_busy = busy; end
    if (timeout_err)  begin n_to++;    ev_to = cyc;    ev_busy = busy; end
    if (missed_trig)  begin n_miss++;  ev_miss = cyc; end
    @(posedge clk);
    #1;
    cyc++;
    trigger      = 1'b0;
    drp.drp_drdy = 1'b0;
    drp.drp_do   = 16'h0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        drp.drp_drdy = 1'b1;
        drp.drp_do   = resp_data[cur_slot];
      end
    end
  endtask

  task automatic run_frame(input int budget);
    ev_valid = -1;
    ev_to    = -1;
    t0       = cyc;
    trigger  = 1'b1;
    for (int i = 0; i < budget && ev_valid < 0 && ev_to < 0; i++) tick();
  endtask

  initial begin
    drp.drp_drdy = 1'b0;
    drp.drp_do   = 16'h0;
    vecs[0] = '{1,  16'hABC0, 16'h1230, 16'h7FF0, 1'b1, 8,   36'h7FF123ABC};
    vecs[1] = '{2,  16'h0010, 16'hFFFF, 16'h8000, 1'b1, 11,  36'h800FFF001};
    vecs[2] = '{5,  16'h1234, 16'h5678, 16'h9ABC, 1'b1, 20,  36'h9AB567123};
    vecs[3] = '{63, 16'h0F0F, 16'hF0F0, 16'hA5A5, 1'b1, 194, 36'hA5AF0F0F0};
    vecs[4] = '{64, 16'h1111, 16'h2222, 16'h3333, 1'b0, 65,  36'hA5AF0F0F0};
    vecs[5] = '{1,  16'h0000, 16'h0000, 16'h0000, 1'b1, 8,   36'h000000000};

    repeat (2) tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(sample_valid), 64'(0));
    chk("rst_data", 64'(sample_data), 64'(0));
    chk("rst_den", 64'(drp.drp_den), 64'(0));
    chk("rst_timeout", 64'(timeout_err), 64'(0));
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) begin
      k_fix = vecs[i].k;
      resp_data[0] = vecs[i].d0;
      resp_data[1] = vecs[i].d1;
      resp_data[2] = vecs[i].d2;
      addr_q.delete();
      v0 = n_valid; to0 = n_to;
      run_frame(300);
      if (vecs[i].exp_ok) begin
        chk("vec_valid_cycle", 64'(ev_valid - t0), 64'(vecs[i].exp_off));
        chk("vec_no_timeout", 64'(n_to - to0), 64'(0));
        chk("vec_addr_order", 64'(pack_addrs()),
            64'({XADC_ADDR_AUX1, XADC_ADDR_AUX0, XADC_ADDR_VPVN}));
      end else begin
        chk("vec_timeout_cycle", 64'(ev_to - t0), 64'(vecs[i].exp_off));
        chk("vec_no_valid", 64'(n_valid - v0), 64'(0));
      end
      chk("vec_data", 64'(sample_data), 64'(vecs[i].exp_data));
      chk("vec_busy_at_event", 64'(ev_busy), 64'(0));
      repeat (3) tick();
    end

    // Overlap: triggers at +3 (REQ) and +7 (DONE) are missed, +8 starts a new frame.
    k_fix = 1;
    resp_data[0] = 16'hABC0; resp_data[1] = 16'h1230; resp_data[2] = 16'h7FF0;
    d0 = n_den; v0 = n_valid; m0 = n_miss;
    t0 = cyc;
    for (int i = 0; i < 24; i++) begin
      if (i == 0 || i == 3 || i == 7 || i == 8) trigger = 1'b1;
      tick();
    end
    chk("ovl_den_count", 64'(n_den - d0), 64'(6));
    chk("ovl_valid_count", 64'(n_valid - v0), 64'(2));
    chk("ovl_missed_count", 64'(n_miss - m0), 64'(2));
    chk("ovl_last_missed", 64'(ev_miss - t0), 64'(7));
    chk("ovl_last_valid", 64'(ev_valid - t0), 64'(16));
    chk("ovl_data", 64'(sample_data), 64'(36'h7FF123ABC));

    // Slot 1 never answers: abort 64 cycles after its den, old frame kept.
    mute_aux0 = 1'b1;
    resp_data[0] = 16'h5550; resp_data[2] = 16'h6660;
    v0 = n_valid;
    run_frame(150);
    chk("to_cycle", 64'(ev_to - t0), 64'(67));
    chk("to_no_valid", 64'(n_valid - v0), 64'(0));
    chk("to_data_kept", 64'(sample_data), 64'(36'h7FF123ABC));
    chk("to_busy", 64'(ev_busy), 64'(0));
    mute_aux0 = 1'b0;
    resp_data[1] = 16'h4440;
    repeat (2) tick();
    addr_q.delete();
    run_frame(50);
    chk("to_restart_slot0", 64'(pack_addrs()),
        64'({XADC_ADDR_AUX1, XADC_ADDR_AUX0, XADC_ADDR_VPVN}));
    chk("to_restart_valid", 64'(ev_valid - t0), 64'(8));
    chk("to_restart_data", 64'(sample_data), 64'(36'h666444555));

    // Stray drdy while idle.
    tick();
    drp.drp_drdy = 1'b1;
    drp.drp_do   = 16'hFFFF;
    d0 = n_den; v0 = n_valid; to0 = n_to;
    repeat (5) tick();
    chk("stray_den", 64'(n_den - d0), 64'(0));
    chk("stray_valid", 64'(n_valid - v0), 64'(0));
    chk("stray_timeout", 64'(n_to - to0), 64'(0));
    chk("stray_data", 64'(sample_data), 64'(36'h666444555));

    // Reset during WAIT of slot 1; its drdy lands after release.
    k_fix = 10;
    t0 = cyc;
    trigger = 1'b1;
    while (cyc < t0 + 14) tick();
    chk("mid_busy_before_rst", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_den", 64'(drp.drp_den), 64'(0));
    chk("mid_rst_data", 64'(sample_data), 64'(0));
    chk("mid_rst_valid", 64'(sample_valid), 64'(0));
    chk("mid_rst_timeout", 64'(timeout_err), 64'(0));
    repeat (3) tick();
    rst_n = 1'b1;
    d0 = n_den; v0 = n_valid; to0 = n_to;
    repeat (20) tick();
    chk("post_rst_den", 64'(n_den - d0), 64'(0));
    chk("post_rst_valid", 64'(n_valid - v0), 64'(0));
    chk("post_rst_timeout", 64'(n_to - to0), 64'(0));
    chk("post_rst_busy", 64'(busy), 64'(0));

    // Random latency 1..20 per read, random data.
    rand_k = 1'b1;
    for (int f = 0; f < 100; f++) begin
      r0 = 16'($urandom); r1 = 16'($urandom); r2 = 16'($urandom);
      resp_data[0] = r0; resp_data[1] = r1; resp_data[2] = r2;
      exp_frame = {r2[15:4], r1[15:4], r0[15:4]};
      run_frame(200);
      chk("rnd_valid_seen", 64'(ev_valid >= 0), 64'(1));
      chk("rnd_data", 64'(sample_data), 64'(exp_frame));
    end
    rand_k = 1'b0;
    repeat (25) tick();
    chk("no_overlapping_den", 64'(n_overlap), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
